// File: rtl/dp_fsm_pkg.sv
// rtl/dp_fsm_pkg.sv - shared types and constants for the audio datapath sequencer
// Contents:
//   DWELL_W : width of the read-strobe dwell counter
//   state_t : sequencer state encoding (all eight 3-bit codes are named)
package dp_fsm_pkg;

  localparam int DWELL_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REV_RD  = 3'd1,
    CHOR_RD = 3'd2,
    MAIN_RD = 3'd3,
    WAIT_TX = 3'd4,
    TFR     = 3'd5,
    TX_HOLD = 3'd6,
    INC     = 3'd7
  } state_t;

endpackage

// File: rtl/dp_dwell_cnt.sv
// rtl/dp_dwell_cnt.sv - clearable saturating dwell counter with terminal-count flag
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   clr_i  : synchronous clear (takes priority over en_i)
//   en_i   : count enable
//   tc_o   : high while the count equals RD_CYCLES-1
module dp_dwell_cnt
  import dp_fsm_pkg::*;
#(
  parameter int RD_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [DWELL_W-1:0] TC_VAL  = DWELL_W'(RD_CYCLES - 1);
  localparam logic [DWELL_W-1:0] CNT_MAX = '1;

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Saturate at all-ones so a stalled enable can never wrap back to a
  // value that would re-fire the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dp_fsm.sv
// rtl/dp_fsm.sv - per-sample datapath sequencer: three RAM reads, transmit handshake, address step
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset, forces IDLE
//   start     : begin a sample cycle (sampled in IDLE only)
//   transmit  : transmitter requests/holds the transfer word (level)
//   rev_read  : reverb delay-line read strobe
//   chor_read : chorus delay-line read strobe
//   main_read : dry sample read strobe
//   tfr_ready : one-clock pulse, transfer word valid
//   inc_adr   : one-clock pulse, advance sample-buffer address
module dp_fsm
  import dp_fsm_pkg::*;
#(
  parameter int RD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic transmit,
  output logic rev_read,
  output logic chor_read,
  output logic main_read,
  output logic tfr_ready,
  output logic inc_adr
);

  state_t state_q;
  state_t state_d;
  logic   dwell_tc;
  logic   cnt_clr;
  logic   cnt_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = REV_RD;
      REV_RD:  if (dwell_tc)  state_d = CHOR_RD;
      CHOR_RD: if (dwell_tc)  state_d = MAIN_RD;
      MAIN_RD: if (dwell_tc)  state_d = WAIT_TX;
      WAIT_TX: if (transmit)  state_d = TFR;
      TFR:                    state_d = TX_HOLD;
      TX_HOLD: if (!transmit) state_d = INC;
      INC:                    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Any state change restarts the dwell count, so each read state starts
  // counting from zero without needing per-state entry logic.
  always_comb begin
    cnt_clr = (state_d != state_q);
    cnt_en  = (state_q == REV_RD) || (state_q == CHOR_RD) || (state_q == MAIN_RD);
  end

  dp_dwell_cnt #(
    .RD_CYCLES (RD_CYCLES)
  ) u_dwell (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (dwell_tc)
  );

  // Moore decode from the state register only; the async reset therefore
  // drops every output without waiting for a clock edge.
  always_comb begin
    rev_read  = 1'b0;
    chor_read = 1'b0;
    main_read = 1'b0;
    tfr_ready = 1'b0;
    inc_adr   = 1'b0;
    case (state_q)
      REV_RD:  rev_read  = 1'b1;
      CHOR_RD: chor_read = 1'b1;
      MAIN_RD: main_read = 1'b1;
      TFR:     tfr_ready = 1'b1;
      INC:     inc_adr   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_fsm.sv
// tb/tb_dp_fsm.sv - directed self-checking bench for dp_fsm (RD_CYCLES 1 and 3)
module tb_dp_fsm;
  import dp_fsm_pkg::*;

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_REV  = 5'b10000;
  localparam logic [4:0] O_CHOR = 5'b01000;
  localparam logic [4:0] O_MAIN = 5'b00100;
  localparam logic [4:0] O_TFR  = 5'b00010;
  localparam logic [4:0] O_INC  = 5'b00001;

  logic clk;
  logic reset;
  logic start;
  logic transmit;

  logic rev1, chor1, main1, tfr1, inc1;
  logic rev3, chor3, main3, tfr3, inc3;
  logic [4:0] o1;
  logic [4:0] o3;

  int n_checks;
  int n_pass;

  logic [4:0] nom_exp [0:9];
  logic [9:0] nom_s;
  logic [9:0] nom_t;
  logic [4:0] rep_exp [0:7];
  logic [7:0] rep_t;

  assign o1 = {rev1, chor1, main1, tfr1, inc1};
  assign o3 = {rev3, chor3, main3, tfr3, inc3};

  dp_fsm #(.RD_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .transmit  (transmit),
    .rev_read  (rev1),
    .chor_read (chor1),
    .main_read (main1),
    .tfr_ready (tfr1),
    .inc_adr   (inc1)
  );

  dp_fsm #(.RD_CYCLES(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .transmit  (transmit),
    .rev_read  (rev3),
    .chor_read (chor3),
    .main_read (main3),
    .tfr_ready (tfr3),
    .inc_adr   (inc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start    = 1'b0;
    transmit = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    nom_s = 10'b0000000001;
    nom_t = 10'b0001111100;
    nom_exp = '{O_REV, O_CHOR, O_MAIN, O_NONE, O_TFR, O_NONE, O_NONE, O_INC, O_NONE, O_NONE};
    rep_t   = 8'b00011000;
    rep_exp = '{O_REV, O_CHOR, O_MAIN, O_NONE, O_TFR, O_NONE, O_INC, O_NONE};

    // Reset held with both inputs high
    reset    = 1'b0;
    start    = 1'b1;
    transmit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out1", 32'(o1), 32'(O_NONE));
      check("rst_out3", 32'(o3), 32'(O_NONE));
      check("rst_state", 32'(dut1.state_q), 32'(IDLE));
    end
    reset = 1'b1;
    tick();
    check("rel_rev1", 32'(o1), 32'(O_REV));
    check("rel_rev3", 32'(o3), 32'(O_REV));

    // Nominal sequence, RD_CYCLES=1
    do_reset();
    for (int i = 0; i < 10; i++) begin
      start    = nom_s[i];
      transmit = nom_t[i];
      tick();
      check($sformatf("nom_%0d", i), 32'(o1), 32'(nom_exp[i]));
    end

    // Dwell, RD_CYCLES=3: 9 read clocks then WAIT_TX
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [4:0] e;
      tick();
      start = 1'b0;
      e = (i < 3) ? O_REV : (i < 6) ? O_CHOR : (i < 9) ? O_MAIN : O_NONE;
      check($sformatf("dwell_%0d", i), 32'(o3), 32'(e));
    end

    // Transmit wait: both instances sit in WAIT_TX
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("wait1_%0d", i), 32'(o1), 32'(O_NONE));
      check($sformatf("wait3_%0d", i), 32'(o3), 32'(O_NONE));
    end
    transmit = 1'b1;
    tick();
    check("tfr1", 32'(o1), 32'(O_TFR));
    check("tfr3", 32'(o3), 32'(O_TFR));
    transmit = 1'b0;
    tick();
    check("hold1", 32'(o1), 32'(O_NONE));
    tick();
    check("inc1", 32'(o1), 32'(O_INC));
    check("inc3", 32'(o3), 32'(O_INC));
    tick();
    check("idle1", 32'(o1), 32'(O_NONE));
    check("idle_st", 32'(dut1.state_q), 32'(IDLE));

    // Mid-sequence asynchronous reset during chor_read
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_chor", 32'(o1), 32'(O_CHOR));
    #2;
    reset = 1'b0;
    #1;
    check("mid_async_out", 32'(o1), 32'(O_NONE));
    check("mid_async_st", 32'(dut1.state_q), 32'(IDLE));
    tick();
    transmit = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("noinc1_%0d", i), 32'(o1), 32'(O_NONE));
      check($sformatf("noinc3_%0d", i), 32'(o3), 32'(O_NONE));
    end
    transmit = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("restart1", 32'(o1), 32'(O_REV));
    check("restart3", 32'(o3), 32'(O_REV));

    // start held high: back-to-back sequences, one IDLE clock between
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      transmit = rep_t[i % 8];
      tick();
      check($sformatf("rep_%0d", i), 32'(o1), 32'(rep_exp[i % 8]));
      check($sformatf("onehot1_%0d", i), 32'($countones(o1) <= 1), 32'd1);
      check($sformatf("onehot3_%0d", i), 32'($countones(o3) <= 1), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
